// File: rtl/mips_mem_arbiter_pkg.sv
// Shared widths, arbiter defaults and FSM state encoding for mips_mem_arbiter.
// Optional watchdog is enabled by defining MIPS_ARB_TIMEOUT_EN.
`ifndef MIPS_ADDR_WIDTH
`define MIPS_ADDR_WIDTH 32
`endif
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif
`ifndef MIPS_ARB_BURST_LEN
`define MIPS_ARB_BURST_LEN 4
`endif
`ifndef MIPS_ARB_STARVE_MAX
`define MIPS_ARB_STARVE_MAX 8
`endif
`ifndef MIPS_ARB_TIMEOUT
`define MIPS_ARB_TIMEOUT 255
`endif

package mips_mem_arbiter_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  function automatic int beat_width(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction
endpackage

// File: rtl/mips_arb_beat_ctr.sv
// Beat counter for one burst: tracks the beat index, flags the last beat and
// composes the wrapped beat address from the line base.
module mips_arb_beat_ctr
  import mips_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 30,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              last,
  output logic [ADDR_W-1:0] beat_addr
);
  localparam int BW = beat_width(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [BW-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (clr) begin
      beat_d = {BW{1'b0}};
    end else if (inc) begin
      beat_d = beat_q + BW'(1);
    end else begin
      beat_d = beat_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= {BW{1'b0}};
    end else begin
      beat_q <= beat_d;
    end
  end

  assign last = (beat_q == LAST_BEAT);

  // Line base has its low beat bits zero, so the beat index replaces them.
  if (BURST_LEN > 1) begin : g_wrap
    logic unused_lsb_s;
    assign unused_lsb_s = ^base_addr[BW-1:0];
    assign beat_addr    = {base_addr[ADDR_W-1:BW], beat_q};
  end else begin : g_single
    assign beat_addr = base_addr;
  end
endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the external memory port between I-cache refills and D-cache
// refills/writebacks; D has priority, a starvation counter protects I.
// Define MIPS_ARB_TIMEOUT_EN to add the mem_ack watchdog and sticky arb_err.
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = `MIPS_ADDR_WIDTH - 2,
  parameter int DATA_W     = `MIPS_DATA_WIDTH,
  parameter int BURST_LEN  = `MIPS_ARB_BURST_LEN,
  parameter int STARVE_MAX = `MIPS_ARB_STARVE_MAX
`ifdef MIPS_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = `MIPS_ARB_TIMEOUT
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_beat,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              arb_err_q, arb_err_d;
  logic              gnt_i_s, gnt_d_s, ack_s, last_s, timeout_s, go_idle_s;
  logic [ADDR_W-1:0] base_s, beat_addr_s;

  assign gnt_i_s   = (state_q == GNT_I);
  assign gnt_d_s   = (state_q == GNT_D);
  assign ack_s     = mem_ack & (gnt_i_s | gnt_d_s);
  assign go_idle_s = (ack_s & last_s) | timeout_s;
  assign base_s    = gnt_d_s ? d_addr : i_addr;

  mips_arb_beat_ctr #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN)
  ) u_beat_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (go_idle_s),
    .inc       (ack_s),
    .base_addr (base_s),
    .last      (last_s),
    .beat_addr (beat_addr_s)
  );

`ifdef MIPS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wdog_q, wdog_d;

  // Fires on the TIMEOUT-th consecutive granted cycle without an ack.
  assign timeout_s = (gnt_i_s | gnt_d_s) & ~mem_ack & (wdog_q == WD_LAST);

  always_comb begin
    wdog_d = wdog_q;
    if (!(gnt_i_s | gnt_d_s) || mem_ack || timeout_s) begin
      wdog_d = {TW{1'b0}};
    end else begin
      wdog_d = wdog_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= {TW{1'b0}};
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    arb_err_d = arb_err_q | timeout_s;
    case (state_q)
      IDLE: begin
        // starve only reaches the limit while i_req is high, so it saturates here.
        if (d_req && (!i_req || (starve_q < STARVE_LIM))) begin
          state_d  = GNT_D;
          starve_d = i_req ? (starve_q + SW'(1)) : starve_q;
        end else if (i_req) begin
          state_d  = GNT_I;
          starve_d = {SW{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        if (go_idle_s) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      starve_q  <= {SW{1'b0}};
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign mem_req   = gnt_i_s | gnt_d_s;
  assign mem_we    = gnt_d_s & d_we;
  assign mem_addr  = mem_req ? beat_addr_s : {ADDR_W{1'b0}};
  assign mem_wdata = mem_we ? d_wdata : {DATA_W{1'b0}};
  assign i_rvalid  = gnt_i_s & mem_ack;
  assign i_rdata   = gnt_i_s ? mem_rdata : {DATA_W{1'b0}};
  assign i_done    = gnt_i_s & ((mem_ack & last_s) | timeout_s);
  assign d_beat    = gnt_d_s & mem_ack;
  assign d_rdata   = gnt_d_s ? mem_rdata : {DATA_W{1'b0}};
  assign d_done    = gnt_d_s & ((mem_ack & last_s) | timeout_s);
  assign arb_err   = arb_err_q;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios plus random
// traffic against a transaction-level model of the arbitration rules.
module tb_mips_mem_arbiter;
  localparam int AW = 30, DW = 32, B = 4, SMAX = 8;
`ifdef MIPS_ARB_TIMEOUT_EN
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic i_req, i_rvalid, i_done, d_req, d_we, d_beat, d_done;
  logic mem_req, mem_we, mem_ack, arb_err;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(B), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_beat(d_beat), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_bad = 0;
  // Model: owner 0 = nobody, 1 = I side, 2 = D side; beat counts completed beats.
  int m_owner, m_beat, m_starve, m_nack;
  bit m_err, exp_idone, exp_ddone;
  int i_rate, d_rate, ack_pct, ack_every, cyc, dbeat_cnt;
  int done_log[$];
  logic [AW-1:0] addr_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_beat = 0; m_starve = 0; m_nack = 0; m_err = 1'b0;
    exp_idone = 1'b0; exp_ddone = 1'b0;
  endtask

  task automatic drive();
    logic [AW-1:0] a;
    if (i_req && exp_idone) i_req = 1'b0;
    if (d_req && exp_ddone) d_req = 1'b0;
    if (!i_req && int'($urandom_range(99)) < i_rate) begin
      a = AW'($urandom); a = a & ~AW'(B - 1); i_addr = a; i_req = 1'b1;
    end
    if (!d_req && int'($urandom_range(99)) < d_rate) begin
      a = AW'($urandom); a = a & ~AW'(B - 1); d_addr = a; d_req = 1'b1;
      d_we = 1'($urandom_range(1));
    end
    d_wdata   = DW'($urandom);
    mem_rdata = DW'($urandom);
    if (ack_every > 0) mem_ack = ((cyc % ack_every) == ack_every - 1);
    else               mem_ack = (int'($urandom_range(99)) < ack_pct);
    cyc++;
  endtask

  task automatic step();
    logic [AW-1:0] base;
    bit tmo, dwr;
    #1;
    tmo = 1'b0;
`ifdef MIPS_ARB_TIMEOUT_EN
    tmo = (m_owner != 0) && !mem_ack && (m_nack + 1 == TMO);
`endif
    base = (m_owner == 2) ? d_addr : i_addr;
    dwr  = (m_owner == 2) && d_we;
    exp_idone = (m_owner == 1) && ((mem_ack && m_beat == B - 1) || tmo);
    exp_ddone = (m_owner == 2) && ((mem_ack && m_beat == B - 1) || tmo);
    chk("mem_req", 64'(mem_req), 64'(m_owner != 0));
    chk("mem_addr", 64'(mem_addr), (m_owner != 0) ? 64'(base) + 64'(m_beat) : 64'd0);
    chk("mem_we", 64'(mem_we), 64'(dwr));
    if (dwr) chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
    chk("i_rvalid", 64'(i_rvalid), 64'((m_owner == 1) && mem_ack));
    if (m_owner == 1 && mem_ack) chk("i_rdata", 64'(i_rdata), 64'(mem_rdata));
    chk("i_done", 64'(i_done), 64'(exp_idone));
    chk("d_beat", 64'(d_beat), 64'((m_owner == 2) && mem_ack));
    if (m_owner == 2 && mem_ack && !d_we) chk("d_rdata", 64'(d_rdata), 64'(mem_rdata));
    chk("d_done", 64'(d_done), 64'(exp_ddone));
    chk("arb_err", 64'(arb_err), 64'(m_err));
    if (i_done) done_log.push_back(1);
    if (d_done) done_log.push_back(2);
    if (mem_req && mem_ack) addr_log.push_back(mem_addr);
    if (d_beat) dbeat_cnt++;
    @(posedge clk);
    if (m_owner == 0) begin
      m_beat = 0; m_nack = 0;
      if (d_req && (!i_req || m_starve < SMAX)) begin
        m_owner = 2;
        if (i_req && m_starve < SMAX) m_starve++;
      end else if (i_req) begin
        m_owner = 1; m_starve = 0;
      end
    end else if (tmo) begin
      m_owner = 0; m_beat = 0; m_nack = 0; m_err = 1'b1;
    end else if (mem_ack) begin
      m_beat++; m_nack = 0;
      if (m_beat == B) begin m_owner = 0; m_beat = 0; end
    end else begin
      m_nack++;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin drive(); step(); end
  endtask

  always @(negedge clk)
    if (rst_n && ((m_owner == 1 && !i_req) || (m_owner == 2 && !d_req)))
      $error("protocol: active request dropped mid-burst");

  initial begin
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    i_rate = 0; d_rate = 0; ack_pct = 0; ack_every = 0; cyc = 0; dbeat_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_i_done", 64'(i_done), 64'd0);
    chk("rst_d_done", 64'(d_done), 64'd0);
    chk("rst_arb_err", 64'(arb_err), 64'd0);
    rst_n = 1'b1;

    // Single I burst at 0x40 with an ack every cycle.
    i_addr = 30'h40; i_req = 1'b1; ack_every = 1;
    addr_log.delete(); done_log.delete();
    run(7);
    chk("t1_beats", 64'(addr_log.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk("t1_addr", (k < addr_log.size()) ? 64'(addr_log[k]) : 64'hdead, 64'h40 + 64'(k));
    chk("t1_done_cnt", 64'(done_log.size()), 64'd1);
    chk("t1_done_side", (done_log.size() > 0) ? 64'(done_log[0]) : 64'd0, 64'd1);

    // Both sides always requesting: D wins eight times, then I, then D again.
    done_log.delete(); i_rate = 100; d_rate = 100;
    run(60);
    i_rate = 0; d_rate = 0;
    run(20);
    for (int k = 0; k < 10; k++)
      chk("t2_order", (k < done_log.size()) ? 64'(done_log[k]) : 64'd0,
          (k == 8) ? 64'd1 : 64'd2);

    // D write with an ack every third cycle.
    d_addr = 30'h1230; d_we = 1'b1; d_req = 1'b1; ack_every = 3; cyc = 0;
    dbeat_cnt = 0; done_log.delete();
    run(20);
    chk("t3_dbeats", 64'(dbeat_cnt), 64'd4);
    chk("t3_done_cnt", 64'(done_log.size()), 64'd1);

    // Reset during beat 2 of an I burst.
    i_addr = 30'h80; i_req = 1'b1; ack_every = 1;
    run(3);
    drive();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_mem_req_async", 64'(mem_req), 64'd0);
    chk("t4_i_rvalid_async", 64'(i_rvalid), 64'd0);
    model_reset(); i_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_addr = 30'h80; i_req = 1'b1; addr_log.delete();
    run(6);
    chk("t4_restart_addr", (addr_log.size() > 0) ? 64'(addr_log[0]) : 64'hdead, 64'h80);

    // Random traffic, then drain.
    i_rate = 20; d_rate = 30; ack_every = 0; ack_pct = 60;
    run(2000);
    i_rate = 0; d_rate = 0; ack_pct = 100;
    run(20);

    // Memory never acks.
    i_addr = 30'h200; i_req = 1'b1; ack_pct = 0; done_log.delete();
    run(300);
    #1;
`ifdef MIPS_ARB_TIMEOUT_EN
    chk("t6_arb_err", 64'(arb_err), 64'd1);
    chk("t6_mem_req", 64'(mem_req), 64'd0);
    chk("t6_done_cnt", 64'(done_log.size()), 64'd1);
`else
    chk("t6_arb_err", 64'(arb_err), 64'd0);
    chk("t6_mem_req", 64'(mem_req), 64'd1);
    chk("t6_done_cnt", 64'(done_log.size()), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the single external memory port between instruction-cache refills and data-cache refills/writebacks.
- Sits between the I-cache/D-cache miss logic and the memory bus; the core sees only I_stall/D_stall.
- Grants one requester per burst of BURST_LEN word beats.
- D-side has priority; a starvation counter guarantees I-side progress.

Parameters:
- ADDR_W, 30: word-address width (MIPS_ADDR_WIDTH-2).
- DATA_W, 32: beat width (MIPS_DATA_WIDTH).
- BURST_LEN, 4: beats per burst; power of two, >=1.
- STARVE_MAX, 8: consecutive D grants tolerated while I waits.
- TIMEOUT, 255: cycles without mem_ack before abort (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  I-side burst read request, held until i_done
- i_addr  in  ADDR_W  I-side line base address, low log2(BURST_LEN) bits zero
- i_rvalid  out  1  I-side read beat valid
- i_rdata  out  DATA_W  I-side read beat data
- i_done  out  1  one-cycle pulse on the last I-side beat
- d_req  in  1  D-side burst request, held until d_done
- d_we  in  1  D-side direction: 1 write, 0 read; stable while d_req is high
- d_addr  in  ADDR_W  D-side line base address
- d_wdata  in  DATA_W  current write beat; advances after each d_beat
- d_beat  out  1  D-side beat accepted (read data valid, or write beat consumed)
- d_rdata  out  DATA_W  D-side read beat data
- d_done  out  1  one-cycle pulse on the last D-side beat
- mem_req  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  beat address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory beat completion
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- arb_err  out  1  sticky timeout error

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, beat=0, starve=0, arb_err=0, all outputs 0.
- States:
  - IDLE -> GNT_D when d_req and (!i_req or starve<STARVE_MAX).
  - IDLE -> GNT_I when i_req and (!d_req or starve==STARVE_MAX).
  - GNT_x -> IDLE on mem_ack with beat==BURST_LEN-1.
  - Every burst is followed by one IDLE cycle; there are no back-to-back grants.
- Outputs in GNT_x:
  - mem_req=1.
  - mem_we = d_we in GNT_D, 0 in GNT_I.
  - mem_addr = {base[ADDR_W-1:log2B], beat}; beat wraps within the line.
  - mem_wdata = d_wdata, passed combinationally.
- Beat handling:
  - beat increments on mem_ack and clears on return to IDLE.
  - Beat counter width is max(1, $clog2(BURST_LEN)).
  - i_rvalid/d_beat = mem_ack gated by the current grant.
  - i_rdata/d_rdata = mem_rdata, combinational, no added latency.
  - i_done/d_done = mem_ack on the last beat.
- Minimum burst time: BURST_LEN cycles plus memory wait states, plus one IDLE cycle.
- Starvation counter:
  - starve increments, saturating at STARVE_MAX, on each D grant taken while i_req is high.
  - starve clears on an I grant.
- Boundary conditions:
  - mem_ack in IDLE is ignored.
  - Deassertion of the active req mid-burst is illegal; the burst completes and a bench assertion flags it.
  - With BURST_LEN=1, every beat is the last beat.
  - Reset mid-burst aborts immediately; requesters must re-request.

Optional Feature:
- Macro: MIPS_ARB_TIMEOUT_EN.
- Enabled:
  - A watchdog counts cycles in GNT_x without mem_ack and resets on each ack.
  - When the count reaches TIMEOUT, the arbiter pulses the granted x_done with no beat, returns to IDLE, and sets arb_err.
  - arb_err stays set until reset.
- Disabled:
  - No watchdog logic; arb_err is tied 0.
  - A burst waits indefinitely for mem_ack.

Decomposition:
- Shared package/defines:
  - State encoding (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2).
  - Defaults for BURST_LEN/STARVE_MAX/TIMEOUT as MIPS_ARB_* defines alongside the existing MIPS_*_WIDTH defines.
- Sub-module: mips_arb_beat_ctr, which provides the beat counter, the last-beat flag and the wrapped address composition.

Test Plan:
- Single I burst: i_req, i_addr=0x40, mem_ack every cycle -> mem_addr 0x40..0x43; 4 i_rvalid beats; i_done on the 4th; one IDLE cycle afterwards.
- Simultaneous requests: i_req and d_req (read) in the same cycle with starve=0 -> D granted first; I granted after d_done plus one IDLE cycle; starve returns to 0.
- Starvation limit: d_req held continuously with i_req high, STARVE_MAX=8 -> 8 D bursts, then the 9th grant goes to I.
- D write with wait states: d_we=1, mem_ack every 3rd cycle -> mem_wdata follows d_wdata per beat; d_beat count is 4; d_done on the last beat.
- Reset mid-burst: rst_n low during beat 2 -> immediate IDLE; mem_req=0 with no clock edge; beat=0 after release.
- Timeout (MIPS_ARB_TIMEOUT_EN): no mem_ack for 255 cycles -> done pulse, arb_err=1 held; without the macro, arb_err stays 0 and mem_req stays high.
